// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with modulus, wrap/saturate mode, sync clear/load and
// registered overflow/underflow pulses.
module up_down_counter_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RstVal = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    assign at_max = (count_q == MaxVal);
    assign at_min = (count_q == '0);

    // Boundary decisions use the decoded flags, so wrap is modulo MAX_VAL+1 and the
    // count can never leave 0..MAX_VAL.
    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (up_down) begin
                if (at_max) begin
                    ovf_d   = 1'b1;
                    count_d = SATURATE ? MaxVal : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_min) begin
                    unf_d   = 1'b1;
                    count_d = SATURATE ? '0 : MaxVal;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RstVal;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

`ifndef SYNTHESIS
    a_pulse_excl : assert property (@(posedge clk) disable iff (!rst_n) !(ovf_q && unf_q));
    a_in_range   : assert property (@(posedge clk) disable iff (!rst_n) count_q <= MaxVal);
`endif

endmodule

// File: tb/tb_up_down_counter_param.sv
// Directed bench: wrapping, saturating and MAX_VAL=0 counters driven from shared inputs.
module tb_up_down_counter_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en, up_down;
    logic [3:0] load_val;

    logic [3:0] cw, cs, cz;
    logic       mw, nw, ow, uw;
    logic       ms, ns, os, us;
    logic       mz, nz, oz, uz;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RST_VAL(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .up_down(up_down), .count(cw), .at_max(mw), .at_min(nw), .ovf(ow), .unf(uw)
    );

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RST_VAL(0)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .up_down(up_down), .count(cs), .at_max(ms), .at_min(ns), .ovf(os), .unf(us)
    );

    up_down_counter_param #(.WIDTH(4), .MAX_VAL(0), .SATURATE(1'b0), .RST_VAL(0)) u_zero (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .up_down(up_down), .count(cz), .at_max(mz), .at_min(nz), .ovf(oz), .unf(uz)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_down = 1'b0; load_val = '0;
        #12;
        check_eq("rst_w_cnt", 32'(cw), 0);
        check_eq("rst_w_ovf", 32'(ow), 0);
        check_eq("rst_w_unf", 32'(uw), 0);
        check_eq("rst_w_min", 32'(nw), 1);
        check_eq("rst_w_max", 32'(mw), 0);
        check_eq("rst_z_max", 32'(mz), 1);
        check_eq("rst_z_min", 32'(nz), 1);

        // Count up through the wrap / saturation point.
        rst_n = 1'b1; en = 1'b1; up_down = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check_eq("up_w_cnt", 32'(cw), 32'(i % 10));
            check_eq("up_w_ovf", 32'(ow), 32'(i == 10));
            check_eq("up_w_max", 32'(mw), 32'(i == 9));
            check_eq("up_s_cnt", 32'(cs), 32'((i < 9) ? i : 9));
            check_eq("up_s_ovf", 32'(os), 32'(i >= 10));
            check_eq("up_z_cnt", 32'(cz), 0);
            check_eq("up_z_ovf", 32'(oz), 1);
            check_eq("up_z_unf", 32'(uz), 0);
        end

        // Load 0, then count down through the underflow.
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        check_eq("ld0_w_cnt", 32'(cw), 0);
        check_eq("ld0_w_min", 32'(nw), 1);
        check_eq("ld0_w_ovf", 32'(ow), 0);
        check_eq("ld0_s_cnt", 32'(cs), 0);
        load = 1'b0; en = 1'b1; up_down = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_eq("dn_w_cnt", 32'(cw), 32'(10 - i));
            check_eq("dn_w_unf", 32'(uw), 32'(i == 1));
            check_eq("dn_w_min", 32'(nw), 0);
            check_eq("dn_s_cnt", 32'(cs), 0);
            check_eq("dn_s_unf", 32'(us), 1);
            check_eq("dn_z_unf", 32'(uz), 1);
            check_eq("dn_z_ovf", 32'(oz), 0);
        end

        // Out-of-range load clamps to MAX_VAL.
        en = 1'b0; load = 1'b1; load_val = 4'd15;
        step();
        check_eq("clamp_w_cnt", 32'(cw), 9);
        check_eq("clamp_w_max", 32'(mw), 1);
        check_eq("clamp_s_cnt", 32'(cs), 9);
        check_eq("clamp_z_cnt", 32'(cz), 0);
        check_eq("clamp_w_unf", 32'(uw), 0);

        // clr beats load.
        clr = 1'b1; load_val = 4'd5;
        step();
        check_eq("clr_w_cnt", 32'(cw), 0);
        check_eq("clr_s_cnt", 32'(cs), 0);

        // load beats en; zero counter must not pulse.
        clr = 1'b0; en = 1'b1; up_down = 1'b1; load_val = 4'd4;
        step();
        check_eq("ld_en_w_cnt", 32'(cw), 4);
        check_eq("ld_en_s_cnt", 32'(cs), 4);
        check_eq("ld_en_z_ovf", 32'(oz), 0);

        load = 1'b0;
        step();
        check_eq("at5_w_cnt", 32'(cw), 5);
        check_eq("at5_z_ovf", 32'(oz), 1);

        // Asynchronous reset mid-cycle.
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_w_cnt", 32'(cw), 0);
        check_eq("arst_s_cnt", 32'(cs), 0);
        check_eq("arst_z_ovf", 32'(oz), 0);
        #2 rst_n = 1'b1;
        step();
        check_eq("rel_w_cnt", 32'(cw), 1);
        check_eq("rel_s_cnt", 32'(cs), 1);
        check_eq("rel_z_ovf", 32'(oz), 1);

        // Idle holds and clears pulses.
        en = 1'b0;
        step();
        check_eq("idle_w_cnt", 32'(cw), 1);
        check_eq("idle_z_ovf", 32'(oz), 0);
        check_eq("idle_w_ovf", 32'(ow), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
